// File: rtl/uart_freq_loader.sv
// UART (8N1, LSB first) receiver feeding a big-endian 4-byte frame assembler that
// loads a nonzero 32-bit half-period count for the LED blink divider.
module uart_freq_loader #(
   parameter int unsigned CLK_HZ       = 12000000,
   parameter int unsigned BAUD         = 115200,
   parameter int unsigned DEFAULT_FREQ = 6000000,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic        clk_i,
   input  logic        rst_s,
   input  logic        rx_i,
   output logic [31:0] freq_o,
   output logic        freq_upd_o,
   output logic        frame_err_o,
   output logic [1:0]  byte_cnt_o
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned BW           = $clog2(CLKS_PER_BIT);
   localparam int unsigned TO_MAX       = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TW           = $clog2(TO_MAX + 1);

   localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TO_LIMIT  = TW'(TO_MAX);
   localparam logic [31:0]   FREQ_RST  = 32'(DEFAULT_FREQ);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state;
   logic          rx_meta;
   logic          rx_sync;
   logic [BW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [23:0]   frame_hi;
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_s) begin
         rx_meta     <= 1'b1;
         rx_sync     <= 1'b1;
         state       <= IDLE;
         bit_cnt     <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         frame_hi    <= '0;
         to_cnt      <= '0;
         byte_cnt_o  <= '0;
         freq_o      <= FREQ_RST;
         freq_upd_o  <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         rx_meta     <= rx_i;
         rx_sync     <= rx_meta;
         freq_upd_o  <= 1'b0;
         frame_err_o <= 1'b0;

         // Timer saturates while a byte is in flight; expiry is only acted on in IDLE.
         if (byte_cnt_o == 2'd0)
            to_cnt <= '0;
         else if (to_cnt != TO_LIMIT)
            to_cnt <= to_cnt + 1'b1;

         case (state)
            IDLE: begin
               bit_cnt <= '0;
               if (byte_cnt_o != 2'd0 && to_cnt == TO_LIMIT) begin
                  byte_cnt_o  <= '0;
                  frame_err_o <= 1'b1;
               end
               if (!rx_sync)
                  state <= START;
            end
            START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rx_sync ? IDLE : DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  shift   <= {rx_sync, shift[7:1]};
                  if (bit_idx == 3'd7)
                     state <= STOP;
                  else
                     bit_idx <= bit_idx + 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  if (rx_sync) begin
                     state  <= IDLE;
                     to_cnt <= '0;
                     if (byte_cnt_o == 2'd3) begin
                        byte_cnt_o <= '0;
                        if ({frame_hi, shift} == 32'd0) begin
                           frame_err_o <= 1'b1;
                        end else begin
                           freq_o     <= {frame_hi, shift};
                           freq_upd_o <= 1'b1;
                        end
                     end else begin
                        frame_hi   <= {frame_hi[15:0], shift};
                        byte_cnt_o <= byte_cnt_o + 2'd1;
                     end
                  end else begin
                     frame_err_o <= 1'b1;
                     byte_cnt_o  <= '0;
                     state       <= BREAK;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            BREAK: begin
               if (rx_sync)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_freq_loader.sv
// Directed bench for uart_freq_loader: table of 4-byte frames plus hand-written
// timeout, broken-stop, glitch and mid-frame reset sequences.
module tb_uart_freq_loader;

   localparam int    PERIOD = 10;
   localparam int    CPB    = 104;
   localparam logic [31:0] DEF = 32'h005B8D80;

   logic        clk = 1'b0;
   logic        rst_s = 1'b0;
   logic        rx = 1'b1;
   logic [31:0] freq;
   logic        freq_upd;
   logic        frame_err;
   logic [1:0]  byte_cnt;

   int checks = 0;
   int failures = 0;
   int upd_n = 0;
   int err_n = 0;
   int both_n = 0;
   longint upd_time = 0;

   uart_freq_loader #(
      .CLK_HZ(12000000),
      .BAUD(115200),
      .DEFAULT_FREQ(6000000),
      .TIMEOUT_BITS(20)
   ) dut (
      .clk_i(clk),
      .rst_s(rst_s),
      .rx_i(rx),
      .freq_o(freq),
      .freq_upd_o(freq_upd),
      .frame_err_o(frame_err),
      .byte_cnt_o(byte_cnt)
   );

   always #(PERIOD/2) clk = ~clk;

   always @(negedge clk) begin
      if (freq_upd) begin
         upd_n++;
         upd_time = $time;
      end
      if (frame_err) err_n++;
      if (freq_upd && frame_err) both_n++;
   end

   typedef struct {
      logic [31:0] data;
      logic [31:0] exp_freq;
      int          exp_upd;
      int          exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      idle(CPB);
      for (int k = 0; k < 8; k++) begin
         rx = b[k];
         idle(CPB);
      end
      rx = stop;
      idle(CPB);
   endtask

   task automatic run_frame(input logic [31:0] data, input logic [31:0] exp_freq,
                            input int exp_upd, input int exp_err);
      int     u0, e0;
      longint t4;
      u0 = upd_n;
      e0 = err_n;
      t4 = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) t4 = $time;
         send_byte(data[31-8*i -: 8], 1'b1);
         check("byte_cnt_step", 32'(byte_cnt), 32'((i + 1) % 4));
      end
      check("freq", freq, exp_freq);
      check("upd_pulses", 32'(upd_n - u0), 32'(exp_upd));
      check("err_pulses", 32'(err_n - e0), 32'(exp_err));
      if (exp_upd == 1)
         check("upd_latency", 32'((upd_time - t4) / PERIOD), 32'd991);
   endtask

   vec_t vecs [5];
   int   u0, e0;

   initial begin
      vecs[0] = '{32'h00002EE0, 32'h00002EE0, 1, 0};
      vecs[1] = '{32'h00000000, 32'h00002EE0, 0, 1};
      vecs[2] = '{32'hDEADBEEF, 32'hDEADBEEF, 1, 0};
      vecs[3] = '{32'h00000100, 32'h00000100, 1, 0};
      vecs[4] = '{32'h80000001, 32'h80000001, 1, 0};

      @(negedge clk);
      idle(5);
      rst_s = 1'b1;
      idle(2000);
      check("reset_freq", freq, DEF);
      check("reset_byte_cnt", 32'(byte_cnt), 32'd0);
      check("reset_upd", 32'(upd_n), 32'd0);
      check("reset_err", 32'(err_n), 32'd0);

      for (int v = 0; v < 5; v++)
         run_frame(vecs[v].data, vecs[v].exp_freq, vecs[v].exp_upd, vecs[v].exp_err);

      // Inter-byte timeout: fires ~2032 cycles after the second byte's task ends.
      e0 = err_n;
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      check("to_partial_cnt", 32'(byte_cnt), 32'd2);
      idle(2020);
      check("to_not_yet", 32'(err_n - e0), 32'd0);
      check("to_cnt_held", 32'(byte_cnt), 32'd2);
      idle(25);
      check("to_fired", 32'(err_n - e0), 32'd1);
      check("to_cnt_clear", 32'(byte_cnt), 32'd0);
      run_frame(32'h00000100, 32'h00000100, 1, 0);

      // Broken stop bit followed by a long break.
      e0 = err_n;
      u0 = upd_n;
      send_byte(8'hA5, 1'b1);
      check("brk_cnt1", 32'(byte_cnt), 32'd1);
      send_byte(8'h5A, 1'b0);
      idle(3000);
      rx = 1'b1;
      idle(300);
      check("brk_err", 32'(err_n - e0), 32'd1);
      check("brk_upd", 32'(upd_n - u0), 32'd0);
      check("brk_cnt", 32'(byte_cnt), 32'd0);
      check("brk_freq", freq, 32'h00000100);
      run_frame(32'h00ABCDEF, 32'h00ABCDEF, 1, 0);

      // Short low glitch on an idle line.
      e0 = err_n;
      u0 = upd_n;
      rx = 1'b0;
      idle(30);
      rx = 1'b1;
      idle(300);
      check("glitch_err", 32'(err_n - e0), 32'd0);
      check("glitch_upd", 32'(upd_n - u0), 32'd0);
      check("glitch_cnt", 32'(byte_cnt), 32'd0);
      check("glitch_freq", freq, 32'h00ABCDEF);

      // Reset in the middle of a frame.
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      check("mid_cnt", 32'(byte_cnt), 32'd2);
      rst_s = 1'b0;
      idle(3);
      check("mid_rst_cnt", 32'(byte_cnt), 32'd0);
      check("mid_rst_freq", freq, DEF);
      rst_s = 1'b1;
      idle(10);
      run_frame(32'h01020304, 32'h01020304, 1, 0);

      check("pulse_overlap", 32'(both_n), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_freq_loader.md
Name: uart_freq_loader

Overview:
- Upstream stage of the LED blink divider: receives a 32-bit half-period count over a UART line and presents it as the divider's `freq_v` input.
- Contains a UART receiver (8N1, LSB first) and a 4-byte frame assembler (big-endian).
- Holds the last accepted value stable. Zero values and malformed frames are rejected, so the divider never sees a count it cannot use.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- DEFAULT_FREQ, 6000000, value driven on `freq_o` after reset. Must be nonzero.
- TIMEOUT_BITS, 20, inter-byte timeout in bit periods. Must be ≥ 11.
- Derived (local): CLKS_PER_BIT = CLK_HZ / BAUD, truncating integer division. Default gives 104.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_s  in  1  reset; synchronous, active-low.
- rx_i  in  1  asynchronous UART receive line; idles high.
- freq_o  out  32  current half-period count; feeds the divider's `freq_v`.
- freq_upd_o  out  1  one-cycle pulse, concurrent with a new `freq_o` value.
- frame_err_o  out  1  one-cycle pulse on any byte or frame rejection.
- byte_cnt_o  out  2  number of bytes held in the current partial frame (0–3).

Behaviour:
- **Reset** (rst_s=0 at a clock edge):
  - `freq_o` = DEFAULT_FREQ; `freq_upd_o` = 0; `frame_err_o` = 0; `byte_cnt_o` = 0.
  - Receive FSM returns to IDLE; timeout and bit counters cleared.
  - A reset mid-byte or mid-frame discards all partial data.
- **Input synchronisation:** `rx_i` passes through a 2-flop synchroniser. "rx" below means the synchronised value.
- **Receive FSM states:**
  - IDLE: rx=0 → START, bit-cycle counter cleared.
  - START: at count CLKS_PER_BIT/2 − 1, sample rx. If 0 → DATA with counter cleared. If 1 → IDLE (glitch, no error).
  - DATA: every CLKS_PER_BIT cycles, sample rx into the shift register, LSB first. After the 8th sample → STOP.
  - STOP: at CLKS_PER_BIT, sample rx.
    - If 1 → byte complete, go to IDLE.
    - If 0 → pulse `frame_err_o`, discard the byte, clear the assembler (`byte_cnt` = 0), go to BREAK.
  - BREAK: wait for rx=1, then → IDLE. Holding the line low never yields repeated errors.
- **Frame assembler:**
  - Completed bytes shift in MSB first; `byte_cnt` increments.
  - On the 4th byte, the candidate is {b0, b1, b2, b3}:
    - Candidate = 0 → pulse `frame_err_o`; `freq_o` unchanged.
    - Otherwise → `freq_o` = candidate and `freq_upd_o` = 1, both on the cycle after the STOP sample.
    - In both cases `byte_cnt` returns to 0.
- **Timeout:**
  - While `byte_cnt` ≠ 0, a counter runs; it reloads on each completed byte.
  - On reaching TIMEOUT_BITS × CLKS_PER_BIT with the FSM in IDLE: `byte_cnt` = 0 and `frame_err_o` pulses.
  - While the FSM is outside IDLE, the counter saturates and does not fire. The expiry is evaluated on return to IDLE.
  - If timeout expiry and byte completion land on the same cycle, the byte wins: it is appended and the counter reloads.
- **Output stability:** `freq_o` changes only on an accepted frame or on reset. It never shows a partial value.
- **Pulse separation:** `freq_upd_o` and `frame_err_o` are never high in the same cycle.
- **Width rules:**
  - The bit-cycle counter is $clog2(CLKS_PER_BIT) bits wide.
  - The timeout counter is $clog2(TIMEOUT_BITS × CLKS_PER_BIT + 1) bits wide.
  - No arithmetic wraps.

Test Plan (default parameters, 104 clocks per bit):
- Reset release, line idle for 2000 cycles → `freq_o` = 0x005B8D80, no pulses, `byte_cnt_o` = 0.
- Send 0x00, 0x00, 0x2E, 0xE0 back-to-back → `freq_o` = 0x00002EE0. `freq_upd_o` is one cycle high, one cycle after the 4th stop-bit sample. `byte_cnt_o` steps 1, 2, 3, 0.
- Send 0x00, 0x00, 0x00, 0x00 → exactly one `frame_err_o` pulse; `freq_o` unchanged; `byte_cnt_o` = 0.
- Send 0x12, 0x34, then idle for 2080 cycles past the last stop bit → `frame_err_o` pulse; `byte_cnt_o` = 0. Then send 0x00, 0x00, 0x01, 0x00 → `freq_o` = 0x00000100.
- Stop bit forced low on byte 2, line held low for 3000 cycles, then released → single `frame_err_o` pulse; `byte_cnt_o` = 0. A following valid 4-byte frame is accepted.
- 30-cycle low glitch on an idle line → no state change. Reset asserted after 2 bytes of a frame → `byte_cnt_o` = 0, `freq_o` = DEFAULT_FREQ; a subsequent full frame is accepted.
